// File: rtl/gate_stimulus_seq.sv
// Gate stimulus sequencer: sweeps all eight 3-bit input patterns into a gate
// under test, captures its two outputs once per pattern and counts the ones.
module gate_stimulus_seq #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned GRAY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y1_in,
  input  logic       y0_in,
  output logic       aa,
  output logic       bb,
  output logic       cc,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic [4:0] sample_vec,
  output logic [3:0] y1_count,
  output logic [3:0] y0_count
);

  localparam int unsigned HW      = 4;
  localparam int unsigned IW      = 3;
  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [HW-1:0]   hold_q;
  logic [IW-1:0]   pat_q;
  logic            busy_q;
  logic            done_q;
  logic            sv_q;
  logic [4:0]      svec_q;
  logic [CW-1:0]   y1c_q;
  logic [CW-1:0]   y0c_q;

  logic            capture_c;
  logic            hold_last_c;
  logic            idx_last_c;
  logic [IW-1:0]   idx_d;
  logic [CW-1:0]   y1c_d;
  logic [CW-1:0]   y0c_d;

  // Map a sweep index onto the driven pattern (binary or reflected Gray).
  function automatic logic [IW-1:0] pattern_of(input logic [IW-1:0] i);
    if (GRAY != 0) begin
      return i ^ (i >> 1);
    end
    return i;
  endfunction

  // Hold-counter decode, next index and saturating response counters.
  always_comb begin
    capture_c   = (hold_q == HW'(SETTLE - 1));
    hold_last_c = (hold_q == HW'(HOLD - 1));
    idx_last_c  = (idx_q == IW'(7));
    idx_d       = IW'(idx_q + IW'(1));
    y1c_d       = y1c_q;
    y0c_d       = y0c_q;
    if (y1_in && (y1c_q < CW'(CNT_MAX))) begin
      y1c_d = CW'(y1c_q + CW'(1));
    end
    if (y0_in && (y0c_q < CW'(CNT_MAX))) begin
      y0c_d = CW'(y0c_q + CW'(1));
    end
  end

  // Sweep FSM with all outputs registered; reset outranks start and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      svec_q  <= '0;
      y1c_q   <= '0;
      y0c_q   <= '0;
    end else begin
      done_q <= 1'b0;
      sv_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            hold_q  <= '0;
            pat_q   <= pattern_of(IW'(0));
            busy_q  <= 1'b1;
            y1c_q   <= '0;
            y0c_q   <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // leave counters and last sample untouched
            state_q <= S_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            if (capture_c) begin
              svec_q <= {pat_q, y1_in, y0_in};
              sv_q   <= 1'b1;
              y1c_q  <= y1c_d;
              y0c_q  <= y0c_d;
            end
            if (hold_last_c) begin
              hold_q <= '0;
              if (idx_last_c) begin
                state_q <= S_DONE;
                idx_q   <= '0;
                pat_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_d;
                pat_q <= pattern_of(idx_d);
              end
            end else begin
              hold_q <= HW'(hold_q + HW'(1));
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          pat_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign aa           = pat_q[2];
  assign bb           = pat_q[1];
  assign cc           = pat_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign sample_vec   = svec_q;
  assign y1_count     = y1c_q;
  assign y0_count     = y0c_q;

endmodule

// File: tb/tb_gate_stimulus_seq.sv
// Scoreboard bench for gate_stimulus_seq: three instances cover binary
// HOLD=4/SETTLE=2, Gray HOLD=4/SETTLE=2 and binary HOLD=2/SETTLE=1.
module tb_gate_stimulus_seq;

  logic clk;
  logic rst;
  logic start0, start1, start2;
  logic abort0, abort1, abort2;
  logic y0_mode0;

  logic aa0, bb0, cc0, busy0, done0, sv0;
  logic aa1, bb1, cc1, busy1, done1, sv1;
  logic aa2, bb2, cc2, busy2, done2, sv2;
  logic [4:0] svec0, svec1, svec2;
  logic [3:0] y1c0, y0c0, y1c1, y0c1, y1c2, y0c2;
  logic y1_0, y0_0, y1_1, y0_1, y1_2, y0_2;

  int n_pass;
  int n_total;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] q2[$];

  int   pos[3];
  logic prev_busy[3];
  logic [2:0] prev_pat[3];

  function automatic logic onehot3(input logic [2:0] p);
    return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
  endfunction

  // Gates under test: y1 = OR of inputs, y0 = exactly-one-high (or 0 on dut0).
  assign y1_0 = aa0 | bb0 | cc0;
  assign y0_0 = y0_mode0 ? onehot3({aa0, bb0, cc0}) : 1'b0;
  assign y1_1 = aa1 | bb1 | cc1;
  assign y0_1 = onehot3({aa1, bb1, cc1});
  assign y1_2 = aa2 | bb2 | cc2;
  assign y0_2 = onehot3({aa2, bb2, cc2});

  gate_stimulus_seq #(.HOLD(4), .SETTLE(2), .GRAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .y1_in(y1_0), .y0_in(y0_0), .aa(aa0), .bb(bb0), .cc(cc0),
    .busy(busy0), .done(done0), .sample_valid(sv0), .sample_vec(svec0),
    .y1_count(y1c0), .y0_count(y0c0)
  );

  gate_stimulus_seq #(.HOLD(4), .SETTLE(2), .GRAY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .y1_in(y1_1), .y0_in(y0_1), .aa(aa1), .bb(bb1), .cc(cc1),
    .busy(busy1), .done(done1), .sample_valid(sv1), .sample_vec(svec1),
    .y1_count(y1c1), .y0_count(y0c1)
  );

  gate_stimulus_seq #(.HOLD(2), .SETTLE(1), .GRAY(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .y1_in(y1_2), .y0_in(y0_2), .aa(aa2), .bb(bb2), .cc(cc2),
    .busy(busy2), .done(done2), .sample_valid(sv2), .sample_vec(svec2),
    .y1_count(y1c2), .y0_count(y0c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [2:0] get_pat(input int d);
    case (d)
      0: return {aa0, bb0, cc0};
      1: return {aa1, bb1, cc1};
      default: return {aa2, bb2, cc2};
    endcase
  endfunction

  function automatic logic [3:0] get_y1c(input int d);
    case (d)
      0: return y1c0;
      1: return y1c1;
      default: return y1c2;
    endcase
  endfunction

  function automatic logic [3:0] get_y0c(input int d);
    case (d)
      0: return y0c0;
      1: return y0c1;
      default: return y0c2;
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic push_exp(input int d, input logic [4:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Binary sweep samples: {pattern, OR, y0} with y0 optionally one-hot.
  task automatic push_binary(input int d, input bit with_y0, input int n);
    for (int k = 0; k < n; k++) begin
      logic [2:0] p;
      p = 3'(k);
      push_exp(d, {p, (p != 3'b000), with_y0 ? onehot3(p) : 1'b0});
    end
  endtask

  // Strobe monitor: tracks cycle-within-pattern and checks each sample.
  task automatic mon_dut(input int d, input logic bsy, input logic [2:0] p,
                         input logic sv, input logic [4:0] vec, input int settle);
    logic [4:0] e;
    bit have;
    if (bsy === 1'b1) begin
      if (!prev_busy[d] || (p != prev_pat[d])) pos[d] = 0;
      else pos[d] = pos[d] + 1;
    end else begin
      pos[d] = 0;
    end
    prev_busy[d] = (bsy === 1'b1);
    prev_pat[d]  = p;
    if (sv === 1'b1) begin
      have = 1'b0;
      e    = '0;
      case (d)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      chk(have, $sformatf("dut%0d unexpected_strobe", d), 1, 0);
      if (have) begin
        chk(vec == e, $sformatf("dut%0d sample_vec", d), int'(vec), int'(e));
        chk(pos[d] == settle, $sformatf("dut%0d strobe_cycle", d), pos[d], settle);
      end
    end
  endtask

  // Called in the first busy cycle; counts busy cycles and checks DONE.
  task automatic wait_done(input int d, input int exp_busy, input int y1e,
                           input int y0e, input string nm);
    int cnt;
    cnt = 0;
    while ((get_busy(d) === 1'b1) && (cnt < 400)) begin
      cnt++;
      @(negedge clk);
    end
    chk(cnt == exp_busy, {nm, " busy_cycles"}, cnt, exp_busy);
    chk(get_done(d) === 1'b1, {nm, " done_pulse"}, int'(get_done(d)), 1);
    chk(get_pat(d) == 3'b000, {nm, " done_pattern"}, int'(get_pat(d)), 0);
    chk(get_y1c(d) == 4'(y1e), {nm, " y1_count"}, int'(get_y1c(d)), y1e);
    chk(get_y0c(d) == 4'(y0e), {nm, " y0_count"}, int'(get_y0c(d)), y0e);
    @(negedge clk);
    chk((get_done(d) === 1'b0) && (get_busy(d) === 1'b0), {nm, " idle_after_done"},
        int'({get_done(d), get_busy(d)}), 0);
  endtask

  task automatic pulse_start(input int d);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
  endtask

  initial begin
    logic [4:0] gray_exp [8];
    bit saw_done;
    bit saw_busy;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    y0_mode0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      prev_busy[i] = 1'b0;
      prev_pat[i] = 3'b000;
    end
    gray_exp[0] = 5'b000_0_0; gray_exp[1] = 5'b001_1_1;
    gray_exp[2] = 5'b011_1_0; gray_exp[3] = 5'b010_1_1;
    gray_exp[4] = 5'b110_1_0; gray_exp[5] = 5'b111_1_0;
    gray_exp[6] = 5'b101_1_0; gray_exp[7] = 5'b100_1_1;

    fork
      forever begin
        @(negedge clk);
        mon_dut(0, busy0, {aa0, bb0, cc0}, sv0, svec0, 2);
        mon_dut(1, busy1, {aa1, bb1, cc1}, sv1, svec1, 2);
        mon_dut(2, busy2, {aa2, bb2, cc2}, sv2, svec2, 1);
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk({aa0, bb0, cc0, busy0, done0, sv0} == 6'b0, "reset outputs", int'({aa0, bb0, cc0, busy0, done0, sv0}), 0);
    chk({svec0, y1c0, y0c0} == 13'b0, "reset data", int'({svec0, y1c0, y0c0}), 0);
    chk({busy1, busy2} == 2'b00, "reset busy others", int'({busy1, busy2}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Binary sweep, OR gate, y0 tied low
    push_binary(0, 1'b0, 8);
    pulse_start(0);
    wait_done(0, 32, 7, 0, "bin");

    // Gray sweep, one-hot y0
    for (int k = 0; k < 8; k++) push_exp(1, gray_exp[k]);
    pulse_start(1);
    wait_done(1, 32, 7, 3, "gray");

    // Short hold sweep
    push_binary(2, 1'b1, 8);
    pulse_start(2);
    wait_done(2, 16, 7, 3, "hold2");

    // Abort in the 2nd cycle of pattern 3
    push_binary(0, 1'b0, 3);
    pulse_start(0);
    repeat (13) @(negedge clk);
    chk({aa0, bb0, cc0} == 3'd3, "abort pre_pattern", int'({aa0, bb0, cc0}), 3);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk({busy0, aa0, bb0, cc0} == 4'b0, "abort outputs", int'({busy0, aa0, bb0, cc0}), 0);
    saw_done = 1'b0;
    repeat (10) begin
      if (done0 === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk(!saw_done, "abort no_done", int'(saw_done), 0);
    chk(y1c0 == 4'd2, "abort y1_count", int'(y1c0), 2);
    chk(y0c0 == 4'd0, "abort y0_count", int'(y0c0), 0);

    // Reset mid-sweep in pattern 5, then a full sweep
    push_binary(0, 1'b0, 5);
    pulse_start(0);
    repeat (21) @(negedge clk);
    chk({aa0, bb0, cc0} == 3'd5, "rst pre_pattern", int'({aa0, bb0, cc0}), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({aa0, bb0, cc0, busy0, done0, sv0} == 6'b0, "midrst outputs", int'({aa0, bb0, cc0, busy0, done0, sv0}), 0);
    chk({svec0, y1c0, y0c0} == 13'b0, "midrst data", int'({svec0, y1c0, y0c0}), 0);
    @(negedge clk);
    push_binary(0, 1'b0, 8);
    pulse_start(0);
    wait_done(0, 32, 7, 0, "after_rst");

    // Start held through a whole sweep: one sweep, then a fresh one after DONE
    push_binary(0, 1'b0, 8);
    push_binary(0, 1'b0, 8);
    start0 = 1'b1;
    @(negedge clk);
    wait_done(0, 32, 7, 0, "held1");
    @(negedge clk);
    start0 = 1'b0;
    chk(busy0 === 1'b1, "held restart", int'(busy0), 1);
    wait_done(0, 32, 7, 0, "held2");

    // Start with abort in IDLE stays idle
    start0 = 1'b1;
    abort0 = 1'b1;
    saw_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy0 !== 1'b0) saw_busy = 1'b1;
    end
    start0 = 1'b0;
    abort0 = 1'b0;
    chk(!saw_busy, "start_abort idle", int'(saw_busy), 0);

    repeat (5) @(negedge clk);
    chk(q0.size() == 0, "dut0 missing_samples", q0.size(), 0);
    chk(q1.size() == 0, "dut1 missing_samples", q1.size(), 0);
    chk(q2.size() == 0, "dut2 missing_samples", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
